// File: rtl/ed25519_stream_pkg.sv
// Shared definitions for the Ed25519 public-key streamer.
// Contents: key width, CRC-8 polynomial, stream FSM state type.
package ed25519_stream_pkg;

  localparam int unsigned KEY_W     = 256;
  localparam logic [7:0]  CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_S_IDLE,
    ST_S_STREAM,
    ST_S_CRC
  } stream_state_e;

endpackage

// File: rtl/ed25519_pubkey_streamer_if.sv
// Beat-stream handshake between the key streamer and a host bridge.
// Signals: valid/data/last driven by the master, ready driven by the slave.
// A transfer occurs on a rising clock edge with valid && ready.
interface ed25519_pubkey_streamer_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/ed25519_crc8.sv
// Combinational CRC-8 update (poly 0x07, no reflection) over one DATA_W-bit beat,
// processing the beat MSB-first.
// Ports: crc_in  - running CRC before the beat
//        data    - beat contents
//        crc_out - running CRC after the beat
module ed25519_crc8
  import ed25519_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [7:0]        crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [7:0]        crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (crc_out[7] ^ data[i]) begin
        crc_out = {crc_out[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        crc_out = {crc_out[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/ed25519_pubkey_streamer.sv
// Captures 256-bit Ed25519 public keys (one-cycle in_valid pulse) and streams each
// key out as DATA_W-bit beats over a valid/ready interface. A one-entry pending
// buffer holds a key that arrives while a stream is in progress; a key arriving
// while pending is full is dropped and sets the sticky overrun flag.
// Ports: clk, rst (async, active-high), in_valid/in_pubkey (key input),
//        out (beat stream, master side), busy, overrun, overrun_clr.
// Build option: define PUBKEY_CRC_EN to append a CRC-8 beat after each key.
module ed25519_pubkey_streamer
  import ed25519_stream_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [KEY_W-1:0]              in_pubkey,
  ed25519_pubkey_streamer_if.master     out,
  output logic                          busy,
  output logic                          overrun,
  input  logic                          overrun_clr
);

  localparam int unsigned BEATS    = KEY_W / DATA_W;
  localparam int unsigned CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  stream_state_e     state_q;
  logic [KEY_W-1:0]  sr_q;
  logic [KEY_W-1:0]  pend_q;
  logic              pend_full_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              overrun_q;

  logic [DATA_W-1:0] key_beat;
  logic [KEY_W-1:0]  sr_shifted;
  logic              xfer;
  logic              at_last_key;
  logic              final_beat;
  logic              final_xfer;
  logic              drop;

  assign key_beat    = LSB_FIRST ? sr_q[DATA_W-1:0] : sr_q[KEY_W-1 -: DATA_W];
  assign sr_shifted  = LSB_FIRST ? (sr_q >> DATA_W) : (sr_q << DATA_W);
  assign out.valid   = (state_q != ST_S_IDLE);
  assign xfer        = out.valid && out.ready;
  assign at_last_key = (state_q == ST_S_STREAM) && (cnt_q == LAST_CNT);

`ifdef PUBKEY_CRC_EN
  logic [7:0] crc_q;
  logic [7:0] crc_nxt;

  ed25519_crc8 #(
    .DATA_W (DATA_W)
  ) u_crc8 (
    .crc_in  (crc_q),
    .data    (key_beat),
    .crc_out (crc_nxt)
  );

  assign final_beat = (state_q == ST_S_CRC);
  assign out.data   = (state_q == ST_S_CRC) ? DATA_W'(crc_q) : key_beat;
`else
  assign final_beat = at_last_key;
  assign out.data   = key_beat;
`endif

  assign final_xfer = xfer && final_beat;
  assign out.last   = final_beat;
  // A key is lost only when both the active slot and pending are occupied and no
  // slot frees up this cycle.
  assign drop       = in_valid && (state_q != ST_S_IDLE) && !final_xfer && pend_full_q;
  assign busy       = (state_q != ST_S_IDLE) || pend_full_q;
  assign overrun    = overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_S_IDLE;
      sr_q        <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
`ifdef PUBKEY_CRC_EN
      crc_q       <= 8'h00;
`endif
    end else begin
      // A new drop wins over a simultaneous clear.
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        ST_S_IDLE: begin
          if (in_valid) begin
            sr_q    <= in_pubkey;
            cnt_q   <= '0;
            state_q <= ST_S_STREAM;
`ifdef PUBKEY_CRC_EN
            crc_q   <= 8'h00;
`endif
          end
        end
        default: begin
          if (final_xfer) begin
            // Chain the next key without a bubble: pending first, then a live input.
            if (pend_full_q) begin
              sr_q    <= pend_q;
              cnt_q   <= '0;
              state_q <= ST_S_STREAM;
              if (in_valid) begin
                pend_q <= in_pubkey;
              end else begin
                pend_full_q <= 1'b0;
              end
`ifdef PUBKEY_CRC_EN
              crc_q <= 8'h00;
`endif
            end else if (in_valid) begin
              sr_q    <= in_pubkey;
              cnt_q   <= '0;
              state_q <= ST_S_STREAM;
`ifdef PUBKEY_CRC_EN
              crc_q   <= 8'h00;
`endif
            end else begin
              state_q <= ST_S_IDLE;
            end
          end else begin
            if (xfer) begin
              sr_q  <= sr_shifted;
              cnt_q <= cnt_q + 1'b1;
`ifdef PUBKEY_CRC_EN
              crc_q <= crc_nxt;
              if (at_last_key) begin
                cnt_q   <= '0;
                state_q <= ST_S_CRC;
              end
`endif
            end
            if (in_valid && !pend_full_q) begin
              pend_q      <= in_pubkey;
              pend_full_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
